// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-port ROM arbiter: port ids, read tag, defaults.
package rom_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_STARVE_LIMIT = 4;

  // Travels with each issued read so the returned byte reaches its requester.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

endpackage

// File: rtl/rom_arb_grant.sv
// Fixed-priority grant (A over B) with a starvation counter that lets B win
// once it has been stalled STARVE_LIMIT consecutive cycles.
module rom_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       a_valid_i,
  input  logic       b_valid_i,
  output logic       a_ready_o,
  output logic       b_ready_o,
  output logic       starve_o,
  output logic [3:0] starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Grants are combinational; b_ready only looks at a_ready, never the reverse.
  always_comb begin
    starve_o  = (cnt_q >= LIMIT);
    a_ready_o = a_valid_i && !(b_valid_i && starve_o);
    b_ready_o = b_valid_i && !a_ready_o;
  end

  // Count consecutive stalled B cycles; clear when B is idle or accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (!b_valid_i || b_ready_o) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_cnt_o = cnt_q;

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-read ROM between a CPU port (A, high priority) and a
// video port (B, low priority). Reads are tagged at issue and the tag follows
// the ROM's one-cycle latency so each byte returns to the port that asked.
//
// Handshake: a request is accepted on the rising edge where X_valid && X_ready
// are both high; the requester holds valid and addr stable until then. Data
// comes back as a one-cycle X_rvalid pulse two cycles after the accept edge,
// with X_rdata holding the value until the next pulse.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          rom_ce,
  output logic [AW-1:0] rom_address,
  input  logic [DW-1:0] rom_q
);

  logic          starve;
  logic [3:0]    starve_cnt;

  logic          rom_ce_q,      rom_ce_d;
  logic [AW-1:0] rom_address_q, rom_address_d;
  tag_t          tag1_q,        tag1_d;
  tag_t          tag2_q,        tag2_d;
  logic          a_rvalid_q,    a_rvalid_d;
  logic [DW-1:0] a_rdata_q,     a_rdata_d;
  logic          b_rvalid_q,    b_rvalid_d;
  logic [DW-1:0] b_rdata_q,     b_rdata_d;

  rom_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .a_valid_i    (a_valid),
    .b_valid_i    (b_valid),
    .a_ready_o    (a_ready),
    .b_ready_o    (b_ready),
    .starve_o     (starve),
    .starve_cnt_o (starve_cnt)
  );

  // Issue, tag shift and return routing; rom_ce drops on idle cycles so the
  // ROM output stays put.
  always_comb begin
    rom_ce_d      = a_ready || b_ready;
    rom_address_d = rom_address_q;
    if (a_ready) begin
      rom_address_d = a_addr;
    end else if (b_ready) begin
      rom_address_d = b_addr;
    end
    tag1_d.valid = a_ready || b_ready;
    tag1_d.port  = b_ready ? PORT_B : PORT_A;
    tag2_d       = tag1_q;

    a_rvalid_d = tag2_q.valid && (tag2_q.port == PORT_A);
    b_rvalid_d = tag2_q.valid && (tag2_q.port == PORT_B);
    a_rdata_d  = a_rvalid_d ? rom_q : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? rom_q : b_rdata_q;
  end

  // Pipeline registers; reset discards any in-flight tags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_ce_q      <= 1'b0;
      rom_address_q <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      a_rvalid_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rvalid_q    <= 1'b0;
      b_rdata_q     <= '0;
    end else begin
      rom_ce_q      <= rom_ce_d;
      rom_address_q <= rom_address_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      a_rvalid_q    <= a_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rvalid_q    <= b_rvalid_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  assign rom_ce      = rom_ce_q;
  assign rom_address = rom_address_q;
  assign a_rvalid    = a_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rvalid    = b_rvalid_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered-read ROM model.
module tb_rom_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_valid;
  logic [15:0] a_addr;
  logic        a_ready;
  logic        a_rvalid;
  logic [7:0]  a_rdata;
  logic        b_valid;
  logic [15:0] b_addr;
  logic        b_ready;
  logic        b_rvalid;
  logic [7:0]  b_rdata;
  logic        rom_ce;
  logic [15:0] rom_address;
  logic [7:0]  rom_q;

  int checks;
  int failures;

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  rom_arbiter #(
    .AW           (16),
    .DW           (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_addr      (a_addr),
    .a_ready     (a_ready),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_valid     (b_valid),
    .b_addr      (b_addr),
    .b_ready     (b_ready),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .rom_ce      (rom_ce),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  // ROM contents: a few marked locations, otherwise the address low byte.
  function automatic logic [7:0] rom_data(input logic [15:0] addr);
    case (addr)
      16'h1234: rom_data = 8'hA5;
      16'h8000: rom_data = 8'h5A;
      16'h0010: rom_data = 8'h11;
      16'h0020: rom_data = 8'h22;
      default:  rom_data = addr[7:0];
    endcase
  endfunction

  // Registered-read ROM with chip enable.
  initial rom_q = 8'h00;
  always @(posedge clock) begin
    if (rom_ce) rom_q <= rom_data(rom_address);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    a_valid = 1'b0; a_addr = '0;
    b_valid = 1'b0; b_addr = '0;
    step();
    step();
    @(negedge clock);
    checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce got=%b exp=0", rom_ce); end
    checks++; if (rom_address !== 16'h0) begin failures++; $display("FAIL reset_rom_address got=%h exp=0000", rom_address); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", a_rvalid, b_rvalid); end
    checks++; if (a_rdata !== 8'h0 || b_rdata !== 8'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=00/00", a_rdata, b_rdata); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_a_only;
    a_valid = 1'b1; a_addr = 16'h1234;
    @(negedge clock);
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL a_only_ready got=%b%b exp=10", a_ready, b_ready); end
    step();
    a_valid = 1'b0; a_addr = '0;
    @(negedge clock);
    checks++; if (rom_ce !== 1'b1 || rom_address !== 16'h1234) begin failures++; $display("FAIL a_only_issue got=%b/%h exp=1/1234", rom_ce, rom_address); end
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL a_only_early_rvalid got=%b exp=0", a_rvalid); end
    @(negedge clock);
    checks++; if (a_rvalid !== 1'b0 || rom_ce !== 1'b0) begin failures++; $display("FAIL a_only_cycle2 got=%b/%b exp=0/0", a_rvalid, rom_ce); end
    @(negedge clock);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'hA5) begin failures++; $display("FAIL a_only_return got=%b/%h exp=1/a5", a_rvalid, a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL a_only_b_rvalid got=%b exp=0", b_rvalid); end
    @(negedge clock);
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'hA5) begin failures++; $display("FAIL a_only_hold got=%b/%h exp=0/a5", a_rvalid, a_rdata); end
    step();
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 9; c++) begin
      a_valid = (c < 4);
      a_addr  = (c < 4) ? 16'(c) : 16'h0;
      @(negedge clock);
      checks++; if (a_ready !== (c < 4)) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, a_ready, (c < 4)); end
      checks++; if (rom_ce !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL b2b_rom_ce c=%0d got=%b exp=%b", c, rom_ce, (c >= 1 && c <= 4)); end
      checks++; if (a_rvalid !== (c >= 3 && c <= 6)) begin failures++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, a_rvalid, (c >= 3 && c <= 6)); end
      if (c >= 3 && c <= 6) begin
        checks++; if (a_rdata !== 8'(c - 3)) begin failures++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, a_rdata, 8'(c - 3)); end
      end
      step();
    end
  endtask

  task automatic test_starvation;
    logic exp_ar;
    logic exp_arv;
    a_addr = 16'h0133;
    b_addr = 16'h8000;
    for (int c = 0; c < 10; c++) begin
      a_valid = (c <= 5);
      b_valid = (c <= 4);
      exp_ar  = (c <= 5) && (c != 4);
      exp_arv = (c >= 3 && c <= 6) || (c == 8);
      @(negedge clock);
      checks++; if (a_ready !== exp_ar) begin failures++; $display("FAIL starve_a_ready c=%0d got=%b exp=%b", c, a_ready, exp_ar); end
      checks++; if (b_ready !== (c == 4)) begin failures++; $display("FAIL starve_b_ready c=%0d got=%b exp=%b", c, b_ready, (c == 4)); end
      checks++; if (a_rvalid !== exp_arv) begin failures++; $display("FAIL starve_a_rvalid c=%0d got=%b exp=%b", c, a_rvalid, exp_arv); end
      checks++; if (b_rvalid !== (c == 7)) begin failures++; $display("FAIL starve_b_rvalid c=%0d got=%b exp=%b", c, b_rvalid, (c == 7)); end
      if (c == 7) begin
        checks++; if (b_rdata !== 8'h5A) begin failures++; $display("FAIL starve_b_rdata got=%h exp=5a", b_rdata); end
      end
      if (exp_arv) begin
        checks++; if (a_rdata !== 8'h33) begin failures++; $display("FAIL starve_a_rdata c=%0d got=%h exp=33", c, a_rdata); end
      end
      step();
    end
    a_addr = '0;
    b_addr = '0;
  endtask

  task automatic test_interleaved;
    for (int c = 0; c < 7; c++) begin
      a_valid = (c == 0);
      a_addr  = (c == 0) ? 16'h0010 : 16'h0;
      b_valid = (c == 1);
      b_addr  = (c == 1) ? 16'h0020 : 16'h0;
      @(negedge clock);
      checks++; if (a_rvalid !== (c == 3)) begin failures++; $display("FAIL inter_a_rvalid c=%0d got=%b exp=%b", c, a_rvalid, (c == 3)); end
      checks++; if (b_rvalid !== (c == 4)) begin failures++; $display("FAIL inter_b_rvalid c=%0d got=%b exp=%b", c, b_rvalid, (c == 4)); end
      checks++; if (a_rdata !== ((c >= 3) ? 8'h11 : 8'h33)) begin failures++; $display("FAIL inter_a_rdata c=%0d got=%h exp=%h", c, a_rdata, ((c >= 3) ? 8'h11 : 8'h33)); end
      checks++; if (b_rdata !== ((c >= 4) ? 8'h22 : 8'h5A)) begin failures++; $display("FAIL inter_b_rdata c=%0d got=%h exp=%h", c, b_rdata, ((c >= 4) ? 8'h22 : 8'h5A)); end
      step();
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_mid_flight;
    a_valid = 1'b1; a_addr = 16'h0005;
    @(negedge clock);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_accept got=%b exp=1", a_ready); end
    step();
    a_valid = 1'b0; a_addr = '0;
    reset_n = 1'b0;
    #1;
    checks++; if (rom_ce !== 1'b0 || rom_address !== 16'h0) begin failures++; $display("FAIL rst_mid_rom got=%b/%h exp=0/0000", rom_ce, rom_address); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 8'h0 || b_rdata !== 8'h0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b%b/%h/%h exp=00/00/00", a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_stale c=%0d got=%b%b exp=00", c, a_rvalid, b_rvalid); end
      step();
    end
    for (int c = 0; c < 5; c++) begin
      a_valid = (c == 0);
      a_addr  = (c == 0) ? 16'h0005 : 16'h0;
      @(negedge clock);
      checks++; if (a_rvalid !== (c == 3)) begin failures++; $display("FAIL rst_after_rvalid c=%0d got=%b exp=%b", c, a_rvalid, (c == 3)); end
      if (c == 3) begin
        checks++; if (a_rdata !== 8'h05) begin failures++; $display("FAIL rst_after_rdata got=%h exp=05", a_rdata); end
      end
      step();
    end
  endtask

  task automatic test_idle;
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL idle_rom_ce c=%0d got=%b exp=0", c, rom_ce); end
      checks++; if (a_rdata !== 8'h05 || b_rdata !== 8'h00) begin failures++; $display("FAIL idle_rdata c=%0d got=%h/%h exp=05/00", c, a_rdata, b_rdata); end
      checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin failures++; $display("FAIL idle_rvalid c=%0d got=%b%b exp=00", c, a_rvalid, b_rvalid); end
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_a_only();
    test_back_to_back();
    test_starvation();
    test_interleaved();
    test_reset_mid_flight();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
